// File: rtl/mixer_pkg.sv
// Shared types and defaults for the mixer sample scheduler (50 MHz clock, 44.1 kHz sample rate).
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_MIX = 2'd2,
        OFFER    = 2'd3
    } sched_state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_CLK_DIV     = 1134;
    localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every CLK_DIV clocks while enabled; held at 0 when disabled.
module sample_tick_gen
    import mixer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_tick = i_enable && w_last;

    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mixer_sample_scheduler.sv
// Starts one mix per sample tick, captures the mixer result and offers it downstream via valid/ready.
// Optional wait-for-mixer watchdog enabled by defining MIXER_SCHED_TIMEOUT_EN.
module mixer_sample_scheduler
    import mixer_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear_err,
    output logic              calcul_en,
    input  logic [DATA_W-1:0] mix_data,
    input  logic              mix_valid,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    sched_state_t      r_state;
    sched_state_t      w_next;
    logic              w_tick;
    logic              w_capture;
    logic              w_timeout;
    logic [DATA_W-1:0] r_sample;
    logic              r_overrun;

    sample_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

`ifdef MIXER_SCHED_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WAIT_W-1:0] r_wait;
    logic              r_timeout_err;

    // A mix_valid on the final wait cycle takes priority over the timeout.
    assign w_timeout   = (r_state == WAIT_MIX) && !mix_valid &&
                         (r_wait == WAIT_W'(TIMEOUT_CYC - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (rst || r_state == START) begin
            r_wait <= '0;
        end else if (r_state == WAIT_MIX) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (clear_err) begin
            r_timeout_err <= 1'b0;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign w_timeout            = 1'b0;
    assign timeout_err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_capture    = 1'b0;
        calcul_en    = 1'b0;
        sample_valid = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_next = START;
                end
            end
            START: begin
                calcul_en = 1'b1;
                w_next    = WAIT_MIX;
            end
            WAIT_MIX: begin
                if (mix_valid) begin
                    w_capture = 1'b1;
                    w_next    = OFFER;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            OFFER: begin
                sample_valid = 1'b1;
                if (sample_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
        end else if (w_capture) begin
            r_sample <= mix_data;
        end
    end

    // Ticks landing mid-transaction are dropped; a simultaneous clear loses to the new error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_tick && r_state != IDLE) begin
            r_overrun <= 1'b1;
        end else if (clear_err) begin
            r_overrun <= 1'b0;
        end
    end

    assign sample_out = r_sample;
    assign overrun    = r_overrun;

endmodule
